// File: rtl/lock_ctrl_if.sv
// Keypad-side bit stream and actuator-side status of the serial password lock.
// chg_req exists only when PWD_CHANGE_EN is defined.
interface lock_ctrl_if;
    logic       in_valid;
    logic       in;
    logic       clear;
`ifdef PWD_CHANGE_EN
    logic       chg_req;
`endif
    logic       unlock;
    logic       alarm;
    logic       busy;
    logic [2:0] fail_cnt;

`ifdef PWD_CHANGE_EN
    modport master (output in_valid, in, clear, chg_req,
                    input  unlock, alarm, busy, fail_cnt);
    modport slave  (input  in_valid, in, clear, chg_req,
                    output unlock, alarm, busy, fail_cnt);
`else
    modport master (output in_valid, in, clear,
                    input  unlock, alarm, busy, fail_cnt);
    modport slave  (input  in_valid, in, clear,
                    output unlock, alarm, busy, fail_cnt);
`endif
endinterface

// File: rtl/lock_ctrl.sv
// Serial password lock sequencer: 16-bit MSB-first entry, compare, timed unlock, fail count, timed lockout.
// Latency: 16th bit sampled at edge t -> CHECK after t -> unlock/alarm registered after edge t+1.
// No backpressure: every in_valid outside IDLE/INPUT/NEWPWD is dropped. Optional PWD_CHANGE_EN adds chg_req/NEWPWD.
module lock_ctrl #(
    parameter logic [15:0] PWD            = 16'h4475,
    parameter int          OPEN_CYCLES    = 16,
    parameter int          LOCK_CYCLES    = 64,
    parameter int          TIMEOUT_CYCLES = 32,
    parameter int          MAX_FAIL       = 3
) (
    input  logic  clk,
    input  logic  rst,
    lock_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INPUT, CHECK, OPEN, LOCKOUT, NEWPWD} state_t;

    state_t      state, state_nxt;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] timer;
    logic [2:0]  fail_cnt;
    logic [2:0]  fail_inc;
    logic        match;
    logic        collecting;
    logic        take_bit;
    logic        unlock_q, alarm_q, busy_q;
    logic        unlock_nxt, alarm_nxt, busy_nxt;

`ifdef PWD_CHANGE_EN
    logic [15:0] pwd_reg;
    assign match = (shreg == pwd_reg);
`else
    assign match = (shreg == PWD);
`endif

    assign collecting = (state == INPUT) || (state == NEWPWD);
    assign take_bit   = collecting && bus.in_valid && !bus.clear;
    assign fail_inc   = (fail_cnt < 3'(MAX_FAIL)) ? fail_cnt + 3'd1 : fail_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = INPUT;
            INPUT, NEWPWD: begin
                if (bus.clear)
                    state_nxt = IDLE;
                else if (bus.in_valid) begin
                    if (bit_cnt == 5'd15)
                        state_nxt = (state == INPUT) ? CHECK : IDLE;
                end else if (gap_cnt == 16'(TIMEOUT_CYCLES - 1))
                    state_nxt = IDLE;
            end
            CHECK: begin
                if (match)                          state_nxt = OPEN;
                else if (fail_inc == 3'(MAX_FAIL))  state_nxt = LOCKOUT;
                else                                state_nxt = IDLE;
            end
            OPEN: begin
                if (bus.clear)                               state_nxt = IDLE;
`ifdef PWD_CHANGE_EN
                else if (bus.chg_req)                        state_nxt = NEWPWD;
`endif
                else if (timer == 16'(OPEN_CYCLES - 1))      state_nxt = IDLE;
            end
            LOCKOUT: if (timer == 16'(LOCK_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        unlock_nxt = (state_nxt == OPEN);
        alarm_nxt  = (state_nxt == LOCKOUT);
        busy_nxt   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unlock_q <= unlock_nxt;
            alarm_q  <= alarm_nxt;
            busy_q   <= busy_nxt;
        end
    end

    // Entry datapath: shift register, bit counter and inter-bit gap timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            shreg   <= {15'd0, bus.in};
            bit_cnt <= 5'd1;
            gap_cnt <= '0;
        end else if (take_bit) begin
            shreg   <= {shreg[14:0], bus.in};
            bit_cnt <= bit_cnt + 5'd1;
            gap_cnt <= '0;
        end else if (collecting && state_nxt == state) begin
            gap_cnt <= gap_cnt + 16'd1;
        end else begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            timer <= '0;
        else if ((state == OPEN || state == LOCKOUT) && state_nxt == state)
            timer <= timer + 16'd1;
        else
            timer <= '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fail_cnt <= '0;
        else if (state == CHECK)
            fail_cnt <= match ? 3'd0 : fail_inc;
        else if (state == LOCKOUT && state_nxt == IDLE)
            fail_cnt <= '0;
    end

`ifdef PWD_CHANGE_EN
    // New password only commits on a complete 16-bit entry; abort keeps the old one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pwd_reg <= PWD;
        else if (state == NEWPWD && take_bit && bit_cnt == 5'd15)
            pwd_reg <= {shreg[14:0], bus.in};
    end
`endif

    assign bus.unlock   = unlock_q;
    assign bus.alarm    = alarm_q;
    assign bus.busy     = busy_q;
    assign bus.fail_cnt = fail_cnt;
endmodule

// File: tb/tb_lock_ctrl.sv
// Directed self-checking bench for lock_ctrl; exercises PWD_CHANGE_EN when that macro is defined.
module tb_lock_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    lock_ctrl_if bus ();

    lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.in_valid = 1'b1;
        bus.in       = b;
        step();
        bus.in_valid = 1'b0;
        bus.in       = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--)
            send_bit(w[i]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        total++; if (bus.unlock !== 1'b0) begin bad++; $display("FAIL reset_unlock got=%b exp=0", bus.unlock); end
        total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0", bus.alarm); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fail_cnt !== 3'd0) begin bad++; $display("FAIL reset_fail_cnt got=%0d exp=0", bus.fail_cnt); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_unlock();
        send_word(16'h4475);
        total++; if (bus.unlock !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL check_cycle unlock=%b busy=%b exp unlock=0 busy=1", bus.unlock, bus.busy); end
        step();
        total++; if (bus.unlock !== 1'b1) begin bad++; $display("FAIL unlock_rise got=%b exp=1", bus.unlock); end
        total++; if (bus.fail_cnt !== 3'd0) begin bad++; $display("FAIL unlock_fail_cnt got=%0d exp=0", bus.fail_cnt); end
        repeat (15) step();
        total++; if (bus.unlock !== 1'b1) begin bad++; $display("FAIL unlock_cycle16 got=%b exp=1", bus.unlock); end
        step();
        total++; if (bus.unlock !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL unlock_end unlock=%b busy=%b exp 0 0", bus.unlock, bus.busy); end
    endtask

    task automatic test_lockout();
        for (int n = 1; n <= 3; n++) begin
            send_word(16'h0000);
            step();
            total++; if (bus.fail_cnt !== 3'(n)) begin bad++; $display("FAIL lock_fail_cnt got=%0d exp=%0d", bus.fail_cnt, n); end
            total++; if (bus.alarm !== (n == 3)) begin bad++; $display("FAIL lock_alarm got=%b exp=%b", bus.alarm, (n == 3)); end
        end
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (58) step();
        total++; if (bus.alarm !== 1'b1 || bus.fail_cnt !== 3'd3) begin bad++; $display("FAIL lock_cycle64 alarm=%b fail=%0d exp 1 3", bus.alarm, bus.fail_cnt); end
        step();
        total++; if (bus.alarm !== 1'b0 || bus.fail_cnt !== 3'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL lock_exit alarm=%b fail=%0d busy=%b exp 0 0 0", bus.alarm, bus.fail_cnt, bus.busy); end
    endtask

    task automatic test_timeout();
        logic [15:0] w;
        send_word(16'h0000);
        step();
        w = 16'h4475;
        for (int i = 15; i >= 8; i--) send_bit(w[i]);
        repeat (31) step();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL timeout_gap31 busy=%b exp=1", bus.busy); end
        step();
        total++; if (bus.busy !== 1'b0 || bus.fail_cnt !== 3'd1) begin bad++; $display("FAIL timeout_gap32 busy=%b fail=%0d exp 0 1", bus.busy, bus.fail_cnt); end
        send_word(16'h4475);
        step();
        total++; if (bus.unlock !== 1'b1 || bus.fail_cnt !== 3'd0) begin bad++; $display("FAIL timeout_reentry unlock=%b fail=%0d exp 1 0", bus.unlock, bus.fail_cnt); end
        repeat (16) step();
    endtask

    task automatic test_clear();
        logic [15:0] w;
        send_word(16'h4475);
        send_bit(1'b1);
        total++; if (bus.unlock !== 1'b1) begin bad++; $display("FAIL check_drop_bit unlock=%b exp=1", bus.unlock); end
        repeat (4) step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        total++; if (bus.unlock !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL clear_open unlock=%b busy=%b exp 0 0", bus.unlock, bus.busy); end
        w = 16'h4475;
        for (int i = 15; i >= 7; i--) send_bit(w[i]);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in       = w[6];
        step();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL clear_entry busy=%b exp=0", bus.busy); end
        send_word(16'h4475);
        step();
        total++; if (bus.unlock !== 1'b1) begin bad++; $display("FAIL clear_then_entry unlock=%b exp=1", bus.unlock); end
        repeat (16) step();
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 3; n++) begin
            send_word(16'h0000);
            step();
        end
        repeat (10) step();
        total++; if (bus.alarm !== 1'b1) begin bad++; $display("FAIL areset_pre alarm=%b exp=1", bus.alarm); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.alarm !== 1'b0 || bus.fail_cnt !== 3'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL areset_now alarm=%b fail=%0d busy=%b exp 0 0 0", bus.alarm, bus.fail_cnt, bus.busy); end
        #1 rst = 1'b1;
        step();
        send_word(16'h4475);
        step();
        total++; if (bus.unlock !== 1'b1) begin bad++; $display("FAIL areset_entry unlock=%b exp=1", bus.unlock); end
        repeat (16) step();
    endtask

`ifdef PWD_CHANGE_EN
    task automatic test_pwd_change();
        send_word(16'h4475);
        step();
        bus.chg_req = 1'b1;
        step();
        bus.chg_req = 1'b0;
        total++; if (bus.unlock !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL chg_enter unlock=%b busy=%b exp 0 1", bus.unlock, bus.busy); end
        send_word(16'h1234);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL chg_done busy=%b exp=0", bus.busy); end
        send_word(16'h4475);
        step();
        total++; if (bus.unlock !== 1'b0 || bus.fail_cnt !== 3'd1) begin bad++; $display("FAIL chg_old_pwd unlock=%b fail=%0d exp 0 1", bus.unlock, bus.fail_cnt); end
        send_word(16'h1234);
        step();
        total++; if (bus.unlock !== 1'b1 || bus.fail_cnt !== 3'd0) begin bad++; $display("FAIL chg_new_pwd unlock=%b fail=%0d exp 1 0", bus.unlock, bus.fail_cnt); end
        repeat (16) step();
    endtask
`endif

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in       = 1'b0;
        bus.clear    = 1'b0;
`ifdef PWD_CHANGE_EN
        bus.chg_req  = 1'b0;
`endif
        test_reset();
        test_unlock();
        test_lockout();
        test_timeout();
        test_clear();
        test_async_reset();
`ifdef PWD_CHANGE_EN
        test_pwd_change();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
